// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core, loader and memory handshake/bus signals around mem_port_arbiter.
// slave: the arbiter's view; master: the requesters' and memory's view.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] core_rdata;
   logic              core_ready;

   logic              ld_req;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic [DATA_W-1:0] ld_rdata;
   logic              ld_ready;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   logic              grant_ld;
   logic              err;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      output core_rdata, core_ready,
      input  ld_req, ld_we, ld_addr, ld_wdata,
      output ld_rdata, ld_ready,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready,
      output grant_ld, err
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      input  core_rdata, core_ready,
      output ld_req, ld_we, ld_addr, ld_wdata,
      input  ld_rdata, ld_ready,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready,
      input  grant_ld, err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified instruction/data memory between the core and the loader/debug port.
// Optional `define ARB_TIMEOUT_EN adds a mem_ready watchdog that aborts a stalled access with err.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned MAX_LD_STREAK  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned   SW         = $clog2(MAX_LD_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LD_STREAK);

   typedef enum logic [1:0] {IDLE, BUSY_CORE, BUSY_LD, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              owner_ld;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] core_rdata_q;
   logic [DATA_W-1:0] ld_rdata_q;
   logic [SW-1:0]     ld_streak;
   logic              pick_ld;
   logic              pick_core;
   logic              busy;
   logic              mem_done;
   logic              timeout_hit;

   // Loader only loses a contested cycle once it has used up its streak.
   assign pick_ld   = bus.ld_req && (!bus.core_req || (ld_streak < STREAK_MAX));
   assign pick_core = bus.core_req && !pick_ld;
   assign busy      = (state == BUSY_CORE) || (state == BUSY_LD);
   assign mem_done  = busy && bus.mem_ready;

   assign bus.mem_we     = we_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.core_rdata = core_rdata_q;
   assign bus.ld_rdata   = ld_rdata_q;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] to_cnt;
   logic          err_flag;

   // Fires on the last tolerated BUSY cycle so mem_req is high for exactly TIMEOUT_CYCLES cycles.
   assign timeout_hit = busy && !bus.mem_ready && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt   <= '0;
         err_flag <= 1'b0;
      end else if (state == IDLE) begin
         to_cnt   <= '0;
         err_flag <= 1'b0;
      end else if (busy && !bus.mem_ready) begin
         to_cnt <= to_cnt + 1'b1;
         if (timeout_hit) err_flag <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pick_ld)        state_nxt = BUSY_LD;
            else if (pick_core) state_nxt = BUSY_CORE;
         end
         BUSY_CORE, BUSY_LD: begin
            if (mem_done || timeout_hit) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_req    = 1'b0;
      bus.grant_ld   = 1'b0;
      bus.core_ready = 1'b0;
      bus.ld_ready   = 1'b0;
      bus.err        = 1'b0;
      case (state)
         BUSY_CORE: bus.mem_req = 1'b1;
         BUSY_LD: begin
            bus.mem_req  = 1'b1;
            bus.grant_ld = 1'b1;
         end
         DONE: begin
            bus.core_ready = !owner_ld;
            bus.ld_ready   = owner_ld;
`ifdef ARB_TIMEOUT_EN
            bus.err        = err_flag;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_ld     <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_rdata_q <= '0;
         ld_rdata_q   <= '0;
         ld_streak    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_ld) begin
                  owner_ld <= 1'b1;
                  we_q     <= bus.ld_we;
                  addr_q   <= bus.ld_addr;
                  wdata_q  <= bus.ld_wdata;
               end else if (pick_core) begin
                  owner_ld <= 1'b0;
                  we_q     <= bus.core_we;
                  addr_q   <= bus.core_addr;
                  wdata_q  <= bus.core_wdata;
               end
               if (pick_core || !bus.core_req)         ld_streak <= '0;
               else if (pick_ld && ld_streak < STREAK_MAX) ld_streak <= ld_streak + 1'b1;
            end
            BUSY_CORE, BUSY_LD: begin
               if (mem_done) begin
                  if (!we_q) begin
                     if (owner_ld) ld_rdata_q   <= bus.mem_rdata;
                     else          core_rdata_q <= bus.mem_rdata;
                  end
               end else if (timeout_hit) begin
                  if (owner_ld) ld_rdata_q   <= '0;
                  else          core_rdata_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level arbitration and memory model.
module tb_mem_port_arbiter;
   localparam int unsigned ADDR_W         = 32;
   localparam int unsigned DATA_W         = 32;
   localparam int unsigned MAX_LD_STREAK  = 4;
   localparam int unsigned TIMEOUT_CYCLES = 8;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [31:0] mem_arr   [16];
   logic [31:0] model_mem [16];
   logic [31:0] exp_core_rdata = '0;
   logic [31:0] exp_ld_rdata = '0;
   int          resp_lat = 0;
   bit          lat_rand = 1'b0;
   bit          junk_en = 1'b0;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .MAX_LD_STREAK(MAX_LD_STREAK), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   function automatic int unsigned idx_of(input logic [31:0] a);
      return int'(a[5:2]);
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = $urandom;
      t.wdata = $urandom;
      return t;
   endfunction

   // Memory responder: lat extra wait cycles after mem_req rises, -1 = never answers.
   initial begin
      int cnt = 0;
      int lat = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!bus.mem_req) begin
            cnt = 0;
            bus.mem_ready = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata = $urandom;
         end else begin
            if (cnt == 0) lat = lat_rand ? int'($urandom_range(0, 3)) : resp_lat;
            cnt++;
            if (lat >= 0 && cnt == lat + 1) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = mem_arr[idx_of(bus.mem_addr)];
               if (bus.mem_we) mem_arr[idx_of(bus.mem_addr)] = bus.mem_wdata;
            end else begin
               bus.mem_ready = 1'b0;
               bus.mem_rdata = $urandom;
            end
         end
      end
   end

   task automatic drive_core(input txn_t t);
      bus.core_req = 1'b1; bus.core_we = t.we; bus.core_addr = t.addr; bus.core_wdata = t.wdata;
   endtask

   task automatic drive_ld(input txn_t t);
      bus.ld_req = 1'b1; bus.ld_we = t.we; bus.ld_addr = t.addr; bus.ld_wdata = t.wdata;
   endtask

   task automatic idle_core();
      bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
   endtask

   task automatic idle_ld();
      bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
   endtask

   task automatic test_reset();
      idle_core(); idle_ld();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.core_ready, bus.ld_ready, bus.grant_ld, bus.err} !== 6'b0 ||
          bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.core_rdata !== '0 || bus.ld_rdata !== '0)
         begin
         failures++;
         $display("FAIL reset_values: req=%b we=%b addr=%h wdata=%h crd=%h lrd=%h rdy=%b%b gl=%b err=%b, all required 0",
                  bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.core_rdata, bus.ld_rdata,
                  bus.core_ready, bus.ld_ready, bus.grant_ld, bus.err);
      end
      rst_n = 1'b1;
      exp_core_rdata = '0;
      exp_ld_rdata = '0;
      @(negedge clk);
   endtask

   task automatic test_core_read();
      int ready_cyc = -1;
      int n_ready = 0;
      mem_arr[4] = 32'hDEAD_BEEF;
      model_mem[4] = 32'hDEAD_BEEF;
      resp_lat = 2;
      bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h0000_0010; bus.core_wdata = $urandom;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            checks++;
            if (bus.mem_req !== 1'b1) begin
               failures++; $display("FAIL core_read_mem_req_c1: got %b want 1", bus.mem_req);
            end
         end
         if (bus.grant_ld !== 1'b0) begin
            failures++; $display("FAIL core_read_grant_ld: got %b want 0 at cycle %0d", bus.grant_ld, cyc);
         end
         if (bus.core_ready === 1'b1) begin
            n_ready++;
            if (ready_cyc < 0) ready_cyc = cyc;
            idle_core();
         end
      end
      checks++;
      if (ready_cyc != 4 || n_ready != 1) begin
         failures++; $display("FAIL core_read_latency: ready cycle %0d count %0d, want cycle 4 count 1", ready_cyc, n_ready);
      end
      exp_core_rdata = 32'hDEAD_BEEF;
      checks++;
      if (bus.core_rdata !== exp_core_rdata) begin
         failures++; $display("FAIL core_read_data: got %h want %h", bus.core_rdata, exp_core_rdata);
      end
   endtask

   task automatic test_ld_write();
      int n_ready = 0;
      int n_bad = 0;
      resp_lat = 3;
      bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h0000_0100; bus.ld_wdata = 32'h1234_5678;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         if (bus.mem_req === 1'b1 && (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 ||
             bus.mem_wdata !== 32'h1234_5678 || bus.grant_ld !== 1'b1)) begin
            n_bad++;
            $display("FAIL ld_write_bus: we=%b addr=%h wdata=%h gl=%b want 1/00000100/12345678/1",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.grant_ld);
         end
         if (bus.ld_ready === 1'b1) begin
            n_ready++;
            idle_ld();
         end
      end
      model_mem[0] = 32'h1234_5678;
      checks++;
      if (n_bad != 0) failures++;
      checks++;
      if (n_ready != 1 || bus.ld_rdata !== exp_ld_rdata) begin
         failures++; $display("FAIL ld_write_done: ready count %0d rdata %h, want 1 and %h", n_ready, bus.ld_rdata, exp_ld_rdata);
      end
   endtask

   task automatic test_withdraw();
      txn_t t;
      txn_t u;
      bit   seen = 1'b0;
      t = rand_txn(); t.we = 1'b0;
      u = rand_txn(); u.we = 1'b0;
      resp_lat = 4;
      drive_core(t);
      for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
         @(negedge clk);
         if (cyc == 2) begin
            bus.core_req = 1'b0; bus.core_addr = ~t.addr; bus.core_we = 1'b1;
            bus.ld_we = 1'b1; bus.ld_addr = $urandom; bus.ld_wdata = $urandom;
         end
         if (bus.core_ready === 1'b1) begin
            seen = 1'b1;
            exp_core_rdata = model_mem[idx_of(t.addr)];
            checks++;
            if (cyc != 6 || bus.core_rdata !== exp_core_rdata) begin
               failures++; $display("FAIL withdraw_done: cycle %0d rdata %h, want cycle 6 rdata %h", cyc, bus.core_rdata, exp_core_rdata);
            end
            resp_lat = 0;
            drive_ld(u);
         end else begin
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== t.addr) begin
               failures++; $display("FAIL withdraw_hold: req=%b we=%b addr=%h want 1/0/%h", bus.mem_req, bus.mem_we, bus.mem_addr, t.addr);
            end
         end
      end
      if (!seen) begin
         checks++; failures++; $display("FAIL withdraw_timeout: core_ready never seen, want one pulse");
         idle_ld();
         return;
      end
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b0) begin
         failures++; $display("FAIL done_wait_idle: mem_req %b want 0 in IDLE after DONE", bus.mem_req);
      end
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.grant_ld !== 1'b1 || bus.mem_addr !== u.addr) begin
         failures++; $display("FAIL done_wait_grant: req=%b gl=%b addr=%h want 1/1/%h", bus.mem_req, bus.grant_ld, bus.mem_addr, u.addr);
      end
      @(negedge clk);
      exp_ld_rdata = model_mem[idx_of(u.addr)];
      checks++;
      if (bus.ld_ready !== 1'b1 || bus.ld_rdata !== exp_ld_rdata) begin
         failures++; $display("FAIL done_wait_ld_read: ready=%b rdata=%h want 1/%h", bus.ld_ready, bus.ld_rdata, exp_ld_rdata);
      end
      idle_ld();
      idle_core();
      @(negedge clk);
   endtask

   // Both sides keep requesting until their queues drain; grant order and data come from the model.
   task automatic run_round(input int n_core, input int n_ld, output string obs);
      txn_t  cq[$];
      txn_t  lq[$];
      txn_t  cur;
      bit    cur_ld = 1'b0;
      bit    prev_req = 1'b0;
      string exp_order = "";
      string g;
      int    s = 0, c = n_core, l = n_ld, gi = 0, cyc = 0;
      obs = "";
      cur = '{we: 1'b0, addr: '0, wdata: '0};
      while (c > 0 || l > 0) begin
         if (l > 0 && (c == 0 || s < int'(MAX_LD_STREAK))) begin
            exp_order = {exp_order, "L"}; l--;
            s = (c > 0) ? s + 1 : 0;
         end else begin
            exp_order = {exp_order, "C"}; c--; s = 0;
         end
      end
      for (int i = 0; i < n_core; i++) cq.push_back(rand_txn());
      for (int i = 0; i < n_ld; i++)   lq.push_back(rand_txn());
      repeat (2) @(negedge clk);
      if (cq.size() > 0) drive_core(cq[0]);
      if (lq.size() > 0) drive_ld(lq[0]);
      while ((cq.size() > 0 || lq.size() > 0) && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (bus.mem_req === 1'b1 && !prev_req) begin
            cur_ld = bus.grant_ld;
            g = cur_ld ? "L" : "C";
            obs = {obs, g};
            checks++;
            if (gi >= exp_order.len() || exp_order.substr(gi, gi) != g || (cur_ld ? lq.size() : cq.size()) == 0) begin
               failures++; $display("FAIL grant_order: grant %0d got %s, expected order %s", gi, g, exp_order);
            end
            gi++;
            if (cur_ld && lq.size() > 0)       cur = lq[0];
            else if (!cur_ld && cq.size() > 0) cur = cq[0];
         end
         if (bus.mem_req === 1'b1) begin
            checks++;
            if (bus.mem_we !== cur.we || bus.mem_addr !== cur.addr || bus.mem_wdata !== cur.wdata || bus.grant_ld !== cur_ld) begin
               failures++; $display("FAIL mem_bus: we=%b addr=%h wdata=%h gl=%b want %b/%h/%h/%b",
                                    bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.grant_ld, cur.we, cur.addr, cur.wdata, cur_ld);
            end
         end
         prev_req = bus.mem_req;
         if (bus.core_ready === 1'b1 || bus.ld_ready === 1'b1) begin
            checks++;
            if (bus.core_ready === bus.ld_ready || bus.ld_ready !== cur_ld) begin
               failures++; $display("FAIL ready_owner: core_ready=%b ld_ready=%b owner_ld=%b", bus.core_ready, bus.ld_ready, cur_ld);
            end
            if (cur.we) model_mem[idx_of(cur.addr)] = cur.wdata;
            else if (cur_ld) exp_ld_rdata = model_mem[idx_of(cur.addr)];
            else exp_core_rdata = model_mem[idx_of(cur.addr)];
            if (bus.ld_ready === 1'b1 && lq.size() > 0) begin
               void'(lq.pop_front());
               if (lq.size() > 0) drive_ld(lq[0]); else idle_ld();
            end
            if (bus.core_ready === 1'b1 && cq.size() > 0) begin
               void'(cq.pop_front());
               if (cq.size() > 0) drive_core(cq[0]); else idle_core();
            end
         end
         checks++;
         if (bus.core_rdata !== exp_core_rdata || bus.ld_rdata !== exp_ld_rdata || bus.err !== 1'b0) begin
            failures++; $display("FAIL rdata_err: crd=%h lrd=%h err=%b want %h/%h/0",
                                 bus.core_rdata, bus.ld_rdata, bus.err, exp_core_rdata, exp_ld_rdata);
         end
      end
      if (cyc >= 400) begin
         checks++; failures++; $display("FAIL round_timeout: %0d core / %0d ld left, want 0/0", cq.size(), lq.size());
      end
      idle_core();
      idle_ld();
   endtask

   task automatic test_starvation();
      string o;
      lat_rand = 1'b0;
      resp_lat = 0;
      run_round(2, 8, o);
      checks++;
      if (o != "LLLLCLLLLC") begin
         failures++; $display("FAIL starvation_order: got %s want LLLLCLLLLC", o);
      end
   endtask

   task automatic test_random();
      string o;
      int    nc, nl;
      lat_rand = 1'b1;
      junk_en = 1'b1;
      for (int r = 0; r < 16; r++) begin
         nc = int'($urandom_range(0, 2));
         nl = int'($urandom_range(0, 7));
         if (nc == 0 && nl == 0) nl = 1;
         run_round(nc, nl, o);
      end
      lat_rand = 1'b0;
      junk_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      txn_t t;
      bit   granted = 1'b0;
      int   ready_cyc = -1;
      t = rand_txn(); t.we = 1'b0;
      resp_lat = -1;
      drive_ld(t);
      for (int cyc = 0; cyc < 5 && !granted; cyc++) begin
         @(negedge clk);
         granted = (bus.grant_ld === 1'b1);
      end
      checks++;
      if (!granted) begin
         failures++; $display("FAIL async_grant: grant_ld never rose, want 1");
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.mem_req !== 1'b0 || bus.grant_ld !== 1'b0 || bus.ld_ready !== 1'b0) begin
         failures++; $display("FAIL async_drop: req=%b gl=%b ld_ready=%b want 0/0/0 before any clock edge",
                              bus.mem_req, bus.grant_ld, bus.ld_ready);
      end
      idle_ld();
      exp_core_rdata = '0;
      exp_ld_rdata = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      resp_lat = 0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk);
         checks++;
         if (bus.mem_req !== 1'b0 || bus.ld_ready !== 1'b0 || bus.ld_rdata !== '0) begin
            failures++; $display("FAIL async_after: req=%b ld_ready=%b lrd=%h want 0/0/0", bus.mem_req, bus.ld_ready, bus.ld_rdata);
         end
      end
      t = rand_txn(); t.we = 1'b0;
      drive_core(t);
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         if (bus.core_ready === 1'b1 && ready_cyc < 0) begin
            ready_cyc = cyc;
            idle_core();
         end
      end
      exp_core_rdata = model_mem[idx_of(t.addr)];
      checks++;
      if (ready_cyc != 2 || bus.core_rdata !== exp_core_rdata) begin
         failures++; $display("FAIL async_idle_access: ready cycle %0d rdata %h want cycle 2 rdata %h", ready_cyc, bus.core_rdata, exp_core_rdata);
      end
   endtask

   task automatic test_timeout();
      txn_t t;
      int   req_cyc = 0;
      int   ready_cyc = -1;
      bit   err_seen = 1'b0;
      t = rand_txn(); t.we = 1'b0;
      resp_lat = -1;
      drive_core(t);
`ifdef ARB_TIMEOUT_EN
      for (int cyc = 1; cyc <= 30 && ready_cyc < 0; cyc++) begin
         @(negedge clk);
         if (bus.mem_req === 1'b1) req_cyc++;
         if (bus.core_ready === 1'b1) begin
            ready_cyc = cyc;
            err_seen = (bus.err === 1'b1);
            idle_core();
         end
      end
      exp_core_rdata = '0;
      checks++;
      if (req_cyc != int'(TIMEOUT_CYCLES) || ready_cyc != int'(TIMEOUT_CYCLES) + 1 || !err_seen) begin
         failures++; $display("FAIL timeout_abort: mem_req cycles %0d ready cycle %0d err %b want %0d/%0d/1",
                              req_cyc, ready_cyc, err_seen, TIMEOUT_CYCLES, TIMEOUT_CYCLES + 1);
      end
      checks++;
      if (bus.core_rdata !== exp_core_rdata) begin
         failures++; $display("FAIL timeout_rdata: got %h want %h", bus.core_rdata, exp_core_rdata);
      end
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0 || bus.core_ready !== 1'b0) begin
         failures++; $display("FAIL timeout_pulse_len: err=%b ready=%b want 0/0", bus.err, bus.core_ready);
      end
`else
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (bus.mem_req === 1'b1) req_cyc++;
         if (bus.core_ready === 1'b1) ready_cyc = cyc;
         if (bus.err === 1'b1) err_seen = 1'b1;
      end
      checks++;
      if (req_cyc != 40 || ready_cyc >= 0 || err_seen) begin
         failures++; $display("FAIL no_timeout_wait: mem_req cycles %0d ready cycle %0d err %b want 40/-1/0",
                              req_cyc, ready_cyc, err_seen);
      end
      idle_core();
      rst_n = 1'b0;
      exp_core_rdata = '0;
      exp_ld_rdata = '0;
      @(negedge clk);
      rst_n = 1'b1;
`endif
      resp_lat = 0;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem_arr[i] = $urandom;
         model_mem[i] = mem_arr[i];
      end
      idle_core();
      idle_ld();
      test_reset();
      test_core_read();
      test_ld_write();
      test_withdraw();
      test_starvation();
      test_random();
      test_async_reset();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: the multi-cycle core (fetch, load and store accesses) and an external program loader/debug port.
- Sits between the core's address mux/write-enable path and the memory macro.
- Sequences each access with a req/ready handshake on both sides.
- Tolerates variable-latency memory through mem_ready.
- Prevents loader starvation of the core with a bounded-streak rule.

Parameters:
- ADDR_W, 32, address width for both requesters and memory.
- DATA_W, 32, data width.
- MAX_LD_STREAK, 4, maximum consecutive loader grants while core_req is pending.
- TIMEOUT_CYCLES, 255, cycles to wait for mem_ready before abort (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- core_req  in  1  core access request; held until core_ready.
- core_we  in  1  core write enable (1 = store).
- core_addr  in  ADDR_W  core byte address.
- core_wdata  in  DATA_W  core store data.
- core_rdata  out  DATA_W  read data, valid from core_ready until the next core completion.
- core_ready  out  1  one-cycle completion pulse for a core access.
- ld_req  in  1  loader request; held until ld_ready.
- ld_we  in  1  loader write enable.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_rdata  out  DATA_W  loader read data, valid from ld_ready until the next loader completion.
- ld_ready  out  1  one-cycle completion pulse for a loader access.
- mem_req  out  1  memory request, held until mem_ready is sampled.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion, sampled only while mem_req = 1.
- grant_ld  out  1  high while the loader owns an in-flight access.
- err  out  1  one-cycle pulse coincident with a ready pulse when that access timed out.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; mem_req, mem_we, mem_addr, mem_wdata = 0; core_rdata, ld_rdata = 0; core_ready, ld_ready, grant_ld, err = 0; ld_streak = 0; timeout counter = 0.
- Reset asserted mid-access: immediate return to IDLE, mem_req drops asynchronously, no ready pulse is issued. The requester re-issues the access after reset.

States:
- IDLE: arbitrate on the current cycle's requests.
- BUSY_CORE / BUSY_LD: mem_* outputs driven from the latched request.
- DONE: ready pulse, mem_req = 0, next state IDLE.

Arbitration (IDLE only):
- Neither requesting: stay in IDLE.
- One requesting: grant it.
- Both requesting: loader wins if ld_streak < MAX_LD_STREAK, otherwise core wins.
- ld_streak update:
  - increments (saturating at MAX_LD_STREAK) on a loader grant while core_req = 1;
  - clears on any core grant;
  - clears in any IDLE cycle with core_req = 0.

On grant:
- Latch we, addr and wdata from the winner into mem_we, mem_addr and mem_wdata.
- Set mem_req = 1 on the next cycle, then hold all four stable until completion.
- grant_ld = 1 throughout BUSY_LD.

Completion:
- mem_req = 1 and mem_ready = 1 in BUSY_x: capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), then enter DONE.
- In DONE, the owner's *_ready pulses for exactly one cycle.

Latency:
- Request seen in IDLE at cycle 0 -> mem_req high at cycle 1 -> mem_ready at cycle k >= 1 -> ready at k+1 -> IDLE at k+2.
- Minimum back-to-back spacing is 3 cycles per access.

Boundary conditions:
- Requester drops req while BUSY: the access still completes and ready still pulses. No abort.
- mem_ready high while mem_req = 0: ignored.
- The non-owner's req/we/addr/wdata inputs are ignored while BUSY.
- A request arriving in DONE waits for the IDLE cycle.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to BUSY_x and increments each BUSY cycle without mem_ready.
  - When the counter reaches TIMEOUT_CYCLES: drop mem_req, write 0 to the owner's rdata, enter DONE, and pulse err with the ready pulse.
  - mem_ready arriving in the same cycle as the timeout wins: normal completion, err = 0.
- Undefined:
  - No counter; BUSY waits for mem_ready indefinitely.
  - err is tied to 0 (the port remains present).

Test Plan:
- Core read alone:
  - Stimulus: core_req = 1, core_we = 0, addr 0x0000_0010; memory returns 0xDEAD_BEEF with mem_ready 2 cycles after mem_req.
  - Response: core_ready pulses once at cycle 4, core_rdata = 0xDEAD_BEEF, grant_ld = 0 throughout.
- Loader write alone:
  - Stimulus: ld_req, ld_we = 1, addr 0x100, wdata 0x1234_5678.
  - Response: mem_we = 1, mem_addr = 0x100, mem_wdata = 0x1234_5678 held stable until mem_ready; ld_ready pulses once; ld_rdata unchanged.
- Starvation bound:
  - Stimulus: core_req and ld_req held high continuously with MAX_LD_STREAK = 4, memory ready in 1 cycle.
  - Response: grant order L,L,L,L,C,L,L,L,L,C; ld_streak clears after each core grant.
- Requester withdrawal:
  - Stimulus: core_req deasserts during BUSY_CORE.
  - Response: mem_req stays high until mem_ready, core_ready still pulses, next grant starts only from IDLE.
- Async reset:
  - Stimulus: rst_n pulled low mid BUSY_LD with mem_ready never asserted.
  - Response: mem_req = 0 with no clock edge; no ld_ready; state IDLE after rst_n rises.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8):
  - Stimulus: mem_ready never asserts.
  - Response: after 8 BUSY cycles, mem_req drops, then core_ready and err pulse together with core_rdata = 0.
  - Same stimulus without the macro: core_ready never pulses and err stays 0.
